// File: rtl/io_port_endpoint_if.sv
// ---------------------------------------------------------------------------
// io_port_endpoint_if
//
// Purpose: groups the MMIO word pair and the peripheral command/response
// handshakes of one io_port_endpoint into a single bundle.
//
// Signals:
//   cmd_word      odd-port output word: [15] toggle T, [14:0] opcode
//   data_word     even-port output word: command operand
//   status_word   odd-port input word: endpoint status
//   rsp_word      even-port input word: held peripheral response
//   dev_cmd_valid / dev_cmd_ready / dev_cmd / dev_data
//                 command FIFO head presented to the peripheral
//   dev_rsp_valid / dev_rsp_ready / dev_rsp_data
//                 response handshake from the peripheral
//
// Modports:
//   slave   endpoint side (io_port_endpoint)
//   master  environment side (MMIO controller + peripheral)
// ---------------------------------------------------------------------------
interface io_port_endpoint_if;
    logic [15:0] cmd_word;
    logic [15:0] data_word;
    logic [15:0] status_word;
    logic [15:0] rsp_word;

    logic        dev_cmd_valid;
    logic        dev_cmd_ready;
    logic [14:0] dev_cmd;
    logic [15:0] dev_data;

    logic        dev_rsp_valid;
    logic        dev_rsp_ready;
    logic [15:0] dev_rsp_data;

    modport slave (
        input  cmd_word,
        input  data_word,
        output status_word,
        output rsp_word,
        output dev_cmd_valid,
        input  dev_cmd_ready,
        output dev_cmd,
        output dev_data,
        input  dev_rsp_valid,
        output dev_rsp_ready,
        input  dev_rsp_data
    );

    modport master (
        output cmd_word,
        output data_word,
        input  status_word,
        input  rsp_word,
        input  dev_cmd_valid,
        output dev_cmd_ready,
        input  dev_cmd,
        input  dev_data,
        output dev_rsp_valid,
        input  dev_rsp_ready,
        output dev_rsp_data
    );
endinterface

// File: rtl/io_port_endpoint.sv
// ---------------------------------------------------------------------------
// io_port_endpoint
//
// Purpose: device-side end of one MMIO port pair. A new CPU command is
// recognised when the toggle bit of cmd_word differs from the last one seen;
// non-ACK commands are queued in a small FIFO and offered to a peripheral
// over a valid/ready handshake. One peripheral response is captured into a
// holding register and published on rsp_word; status_word reports the
// toggle echo, response-valid, overflow, full, fill count and timeout flag.
//
// Ports:
//   clk     system clock, all state updates on posedge
//   rst_n   asynchronous active-low reset
//   io      io_port_endpoint_if.slave (MMIO words + peripheral handshakes)
//
// Parameters:
//   FIFO_DEPTH      command FIFO entries, power of two in 2..8
//   TIMEOUT_CYCLES  head stall limit, 1..65535 (only with IO_EP_TIMEOUT_EN)
//
// Build option:
//   IO_EP_TIMEOUT_EN  when defined, a head entry stalled for TIMEOUT_CYCLES
//                     cycles is discarded and status_word[7] (tmo) is set.
//                     When undefined, status_word[7] is constant 0 and the
//                     head waits indefinitely.
// ---------------------------------------------------------------------------
module io_port_endpoint #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    io_port_endpoint_if.slave io
);

    localparam int         PW      = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("io_port_endpoint: FIFO_DEPTH or TIMEOUT_CYCLES out of range");
    end

    // Entry layout: {opcode[14:0], operand[15:0]}
    logic [30:0]   mem_q [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    count_q, count_d;
    logic          last_t_q, last_t_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   rsp_q, rsp_d;
    logic [15:0]   status_q, status_d;

    logic          head_valid;
    logic          full;
    logic          new_cmd;
    logic          is_ack;
    logic          enq_req;
    logic          enq_ok;
    logic          deq;
    logic          pop;
    logic          capture;
    logic          drop;
    logic          tmo_bit;

    assign head_valid = (count_q != 4'd0);
    assign full       = (count_q == DEPTH_C);
    assign deq        = head_valid && io.dev_cmd_ready;
    assign pop        = deq || drop;
    assign new_cmd    = (io.cmd_word[15] != last_t_q);
    assign is_ack     = new_cmd && (io.cmd_word[14:0] == 15'd0);
    assign enq_req    = new_cmd && (io.cmd_word[14:0] != 15'd0);
    // A full FIFO still takes a command when its head leaves at the same edge.
    assign enq_ok     = enq_req && (!full || pop);
    assign capture    = io.dev_rsp_valid && !rsp_valid_q;

`ifdef IO_EP_TIMEOUT_EN
    localparam logic [16:0] TMO_C = 17'(TIMEOUT_CYCLES);

    logic [15:0] stall_q, stall_d;
    logic        tmo_q, tmo_d;

    always_comb begin
        drop    = head_valid && !io.dev_cmd_ready && (({1'b0, stall_q} + 17'd1) == TMO_C);
        stall_d = stall_q + 16'd1;
        if (!head_valid || deq || drop) begin
            stall_d = 16'd0;
        end
        tmo_d = tmo_q;
        if (is_ack) begin
            tmo_d = 1'b0;
        end
        if (drop) begin
            tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
            tmo_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            tmo_q   <= tmo_d;
        end
    end

    assign tmo_bit = tmo_d;
`else
    assign drop    = 1'b0;
    assign tmo_bit = 1'b0;
`endif

    always_comb begin
        last_t_d    = io.cmd_word[15];
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + 4'(enq_ok) - 4'(pop);
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        ovf_d       = ovf_q;

        if (enq_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // A capture on the same edge as an ACK wins: the new response stays valid.
        if (capture) begin
            rsp_d       = io.dev_rsp_data;
            rsp_valid_d = 1'b1;
        end else if (is_ack) begin
            rsp_valid_d = 1'b0;
        end

        if (is_ack) begin
            ovf_d = 1'b0;
        end else if (enq_req && !enq_ok) begin
            ovf_d = 1'b1;
        end

        // Status is built from next-state values so it is coherent with the
        // state registers in the same cycle.
        status_d = {last_t_d, rsp_valid_d, ovf_d, (count_d == DEPTH_C),
                    count_d, tmo_bit, 7'd0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= 4'd0;
            last_t_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            rsp_q       <= 16'd0;
            status_q    <= 16'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_t_q    <= last_t_d;
            rsp_valid_q <= rsp_valid_d;
            ovf_q       <= ovf_d;
            rsp_q       <= rsp_d;
            status_q    <= status_d;
        end
    end

    // Storage needs no reset: count_q qualifies every read.
    always_ff @(posedge clk) begin
        if (enq_ok) begin
            mem_q[wr_ptr_q] <= {io.cmd_word[14:0], io.data_word};
        end
    end

    // Head fields read as zero while the FIFO is empty.
    assign io.dev_cmd_valid = head_valid;
    assign io.dev_cmd       = head_valid ? mem_q[rd_ptr_q][30:16] : 15'd0;
    assign io.dev_data      = head_valid ? mem_q[rd_ptr_q][15:0]  : 16'd0;
    assign io.dev_rsp_ready = !rsp_valid_q;
    assign io.status_word   = status_q;
    assign io.rsp_word      = rsp_q;

endmodule
